// File: rtl/cache_arbiter_pkg.sv
// Shared mux/select and FSM types for the L1 cache arbiter.
// Imported by the arbiter and by anything that decodes arb_sel.
package cache_arbiter_pkg;

  typedef enum logic {
    d_cache = 1'b0,
    i_cache = 1'b1
  } arbiteraddressmux_sel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arbitermux_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter putting the L1 I-cache and D-cache onto one
// physical-memory port, one whole cache-line transaction at a time.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   icache_read,
  input  logic [ADDR_WIDTH-1:0]  icache_address,
  output logic [LINE_WIDTH-1:0]  icache_rdata,
  output logic                   icache_resp,
  input  logic                   dcache_read,
  input  logic                   dcache_write,
  input  logic [ADDR_WIDTH-1:0]  dcache_address,
  input  logic [LINE_WIDTH-1:0]  dcache_wdata,
  output logic [LINE_WIDTH-1:0]  dcache_rdata,
  output logic                   dcache_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [ADDR_WIDTH-1:0]  pmem_address,
  output logic [LINE_WIDTH-1:0]  pmem_wdata,
  input  logic [LINE_WIDTH-1:0]  pmem_rdata,
  input  logic                   pmem_resp,
  output arbiteraddressmux_sel_t arb_sel
);

  arbitermux_state_t      state_q, state_d;
  arbiteraddressmux_sel_t last_q, last_d;
  arbiteraddressmux_sel_t sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   wr_q, wr_d;

  logic i_req, d_req, grant_i, grant_d, busy;

  always_comb begin
    i_req   = icache_read;
    d_req   = dcache_read | dcache_write;
    // On a tie, the cache that did not go last wins.
    grant_i = i_req & (~d_req | (last_q == d_cache));
    grant_d = d_req & ~grant_i;

    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_i: begin
            state_d = SERVE_I;
            sel_d   = i_cache;
            addr_d  = icache_address;
            wr_d    = 1'b0;
          end
          grant_d: begin
            state_d = SERVE_D;
            sel_d   = d_cache;
            addr_d  = dcache_address;
            wr_d    = dcache_write;
            if (dcache_write) wdata_d = dcache_wdata;
          end
          default: ;
        endcase
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_d = IDLE;
          last_d  = i_cache;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
          last_d  = d_cache;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= i_cache;
      sel_q   <= d_cache;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    busy         = (state_q != IDLE);
    pmem_read    = busy & ~wr_q;
    pmem_write   = busy & wr_q;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    icache_rdata = pmem_rdata;
    dcache_rdata = pmem_rdata;
    icache_resp  = (state_q == SERVE_I) & pmem_resp;
    dcache_resp  = (state_q == SERVE_D) & pmem_resp;
    arb_sel      = sel_q;
  end

  a_no_rd_wr: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(dcache_read && dcache_write)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: vector table plus
// hand-written multi-cycle sequences.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   icache_read;
  logic [31:0]            icache_address;
  logic [255:0]           icache_rdata;
  logic                   icache_resp;
  logic                   dcache_read;
  logic                   dcache_write;
  logic [31:0]            dcache_address;
  logic [255:0]           dcache_wdata;
  logic [255:0]           dcache_rdata;
  logic                   dcache_resp;
  logic                   pmem_read;
  logic                   pmem_write;
  logic [31:0]            pmem_address;
  logic [255:0]           pmem_wdata;
  logic [255:0]           pmem_rdata;
  logic                   pmem_resp;
  arbiteraddressmux_sel_t arb_sel;

  cache_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .arb_sel        (arb_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                   ir;
    logic                   dr;
    logic                   dw;
    logic [31:0]            ia;
    logic [31:0]            da;
    logic                   pr;
    logic                   e_rd;
    logic                   e_wr;
    logic                   e_ir;
    logic                   e_dr;
    arbiteraddressmux_sel_t e_sel;
    logic [31:0]            e_addr;
    logic [255:0]           e_wd;
  } vec_t;

  int checks;
  int errors;

  logic [255:0] line_a5;
  logic [255:0] line_w1;
  logic [255:0] zero_l;
  vec_t         vecs[12];

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr,
                       input logic dw, input logic [31:0] ia,
                       input logic [31:0] da, input logic pr);
    icache_read    = ir;
    dcache_read    = dr;
    dcache_write   = dw;
    icache_address = ia;
    dcache_address = da;
    pmem_resp      = pr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic both_round(input int r);
    drive(1, 1, 0, 32'h1000, 32'h2000, 0);
    chk($sformatf("rr%0d_idle_rd", r), 256'(pmem_read), 256'(1'b0));
    tick();
    drive(1, 1, 0, 32'h1000, 32'h2000, 0);
    chk($sformatf("rr%0d_d_sel", r), 256'(arb_sel), 256'(d_cache));
    chk($sformatf("rr%0d_d_addr", r), 256'(pmem_address),
        256'(32'h2000));
    chk($sformatf("rr%0d_d_rd", r), 256'(pmem_read), 256'(1'b1));
    tick();
    drive(1, 1, 0, 32'h1000, 32'h2000, 1);
    chk($sformatf("rr%0d_d_resp", r), 256'(dcache_resp), 256'(1'b1));
    chk($sformatf("rr%0d_d_iresp", r), 256'(icache_resp), 256'(1'b0));
    tick();
    drive(1, 0, 0, 32'h1000, 32'h2000, 0);
    chk($sformatf("rr%0d_gap_rd", r), 256'(pmem_read), 256'(1'b0));
    tick();
    drive(1, 0, 0, 32'h1000, 32'h2000, 0);
    chk($sformatf("rr%0d_i_sel", r), 256'(arb_sel), 256'(i_cache));
    chk($sformatf("rr%0d_i_addr", r), 256'(pmem_address),
        256'(32'h1000));
    chk($sformatf("rr%0d_i_rd", r), 256'(pmem_read), 256'(1'b1));
    tick();
    drive(1, 0, 0, 32'h1000, 32'h2000, 1);
    chk($sformatf("rr%0d_i_resp", r), 256'(icache_resp), 256'(1'b1));
    chk($sformatf("rr%0d_i_dresp", r), 256'(dcache_resp), 256'(1'b0));
    tick();
    drive(0, 0, 0, 32'h1000, 32'h2000, 0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    line_a5 = {32{8'hA5}};
    line_w1 = {8{32'h1234_5678}};
    zero_l  = '0;

    vecs[0]  = '{1, 0, 0, 32'h40, 32'h0, 0,
                 0, 0, 0, 0, d_cache, 32'h0, zero_l};
    vecs[1]  = '{1, 0, 0, 32'h40, 32'h0, 0,
                 1, 0, 0, 0, i_cache, 32'h40, zero_l};
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = '{1, 0, 0, 32'h40, 32'h0, 1,
                 1, 0, 1, 0, i_cache, 32'h40, zero_l};
    vecs[5]  = '{0, 0, 0, 32'h40, 32'h0, 0,
                 0, 0, 0, 0, i_cache, 32'h40, zero_l};
    vecs[6]  = '{0, 0, 1, 32'h40, 32'h8000_0100, 0,
                 0, 0, 0, 0, i_cache, 32'h40, zero_l};
    vecs[7]  = '{0, 0, 1, 32'h40, 32'h8000_0100, 0,
                 0, 1, 0, 0, d_cache, 32'h8000_0100, line_w1};
    vecs[8]  = '{0, 0, 1, 32'h40, 32'h8000_0100, 1,
                 0, 1, 0, 1, d_cache, 32'h8000_0100, line_w1};
    vecs[9]  = '{0, 0, 0, 32'h40, 32'h8000_0100, 0,
                 0, 0, 0, 0, d_cache, 32'h8000_0100, line_w1};
    vecs[10] = '{0, 0, 0, 32'h40, 32'h8000_0100, 1,
                 0, 0, 0, 0, d_cache, 32'h8000_0100, line_w1};
    vecs[11] = vecs[9];

    rst_n        = 1'b0;
    pmem_rdata   = line_a5;
    dcache_wdata = line_w1;
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    #2;
    chk("rst_rd", 256'(pmem_read), 256'(1'b0));
    chk("rst_wr", 256'(pmem_write), 256'(1'b0));
    chk("rst_sel", 256'(arb_sel), 256'(d_cache));
    chk("rst_addr", 256'(pmem_address), 256'(32'h0));
    chk("rst_wdata", pmem_wdata, zero_l);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ir, vecs[i].dr, vecs[i].dw,
            vecs[i].ia, vecs[i].da, vecs[i].pr);
      chk($sformatf("v%0d_rd", i), 256'(pmem_read), 256'(vecs[i].e_rd));
      chk($sformatf("v%0d_wr", i), 256'(pmem_write), 256'(vecs[i].e_wr));
      chk($sformatf("v%0d_iresp", i), 256'(icache_resp),
          256'(vecs[i].e_ir));
      chk($sformatf("v%0d_dresp", i), 256'(dcache_resp),
          256'(vecs[i].e_dr));
      chk($sformatf("v%0d_sel", i), 256'(arb_sel), 256'(vecs[i].e_sel));
      chk($sformatf("v%0d_addr", i), 256'(pmem_address),
          256'(vecs[i].e_addr));
      chk($sformatf("v%0d_wdata", i), pmem_wdata, vecs[i].e_wd);
      chk($sformatf("v%0d_irdata", i), icache_rdata, line_a5);
      chk($sformatf("v%0d_drdata", i), dcache_rdata, line_a5);
      tick();
    end

    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    both_round(0);
    both_round(1);

    drive(1, 0, 0, 32'h100, 32'h0, 0);
    tick();
    drive(1, 0, 0, 32'h200, 32'h0, 0);
    chk("hold_addr0", 256'(pmem_address), 256'(32'h100));
    tick();
    drive(1, 0, 0, 32'h200, 32'h0, 1);
    chk("hold_addr1", 256'(pmem_address), 256'(32'h100));
    chk("hold_resp", 256'(icache_resp), 256'(1'b1));
    tick();
    drive(0, 0, 0, 32'h200, 32'h0, 0);

    drive(0, 1, 0, 32'h0, 32'h300, 0);
    tick();
    drive(0, 1, 0, 32'h0, 32'h300, 0);
    chk("mid_rd_pre", 256'(pmem_read), 256'(1'b1));
    chk("mid_sel_pre", 256'(arb_sel), 256'(d_cache));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rd_rst", 256'(pmem_read), 256'(1'b0));
    chk("mid_addr_rst", 256'(pmem_address), 256'(32'h0));
    chk("mid_dresp_rst", 256'(dcache_resp), 256'(1'b0));
    @(negedge clk);
    rst_n       = 1'b1;
    dcache_read = 1'b0;
    tick();
    drive(1, 0, 0, 32'h400, 32'h0, 0);
    chk("post_idle_rd", 256'(pmem_read), 256'(1'b0));
    tick();
    drive(1, 0, 0, 32'h400, 32'h0, 0);
    chk("post_rd", 256'(pmem_read), 256'(1'b1));
    chk("post_sel", 256'(arb_sel), 256'(i_cache));
    chk("post_addr", 256'(pmem_address), 256'(32'h400));
    drive(1, 0, 0, 32'h400, 32'h0, 1);
    chk("post_resp", 256'(icache_resp), 256'(1'b1));
    tick();
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
